// File: rtl/carryskip_addsub_pipe_if.sv
// carryskip_addsub_pipe_if: operand/result valid-ready bundle for the carry-skip add/sub pipeline
interface carryskip_addsub_pipe_if #(parameter int WIDTH = 16);
  logic in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, zero;
  logic [WIDTH-1:0] a, b, sum;
  logic [1:0] op;
  modport master(output in_valid, a, b, cin, op, out_ready,
                 input in_ready, out_valid, sum, cout, ovf, zero);
  modport slave(input in_valid, a, b, cin, op, out_ready,
                output in_ready, out_valid, sum, cout, ovf, zero);
endinterface

// File: rtl/carryskip_addsub_pipe.sv
// carryskip_addsub_pipe: pipelined carry-skip add/sub with signed saturation, status flags and global-stall handshake
module carryskip_addsub_pipe #(
  parameter int WIDTH  = 16,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input logic clk,
  input logic rst_n,
  carryskip_addsub_pipe_if.slave io
);
  localparam int G  = WIDTH / (BLOCK * STAGES);
  localparam int SW = G * BLOCK;
  logic adv;
  logic [WIDTH-1:0] raw, sum_n, sum_d, sum_q;
  logic am, bm, ovf_n, cout_d, cout_q, ovf_d, ovf_q, zero_d, zero_q, out_valid_d, out_valid_q;

  function automatic logic [SW:0] skip_add(input logic [SW-1:0] x, input logic [SW-1:0] y, input logic ci);
    logic [SW-1:0] s;
    logic c, rc, p;
    c = ci;
    s = '0;
    for (int g = 0; g < G; g++) begin
      rc = c;
      p  = 1'b1;
      for (int i = 0; i < BLOCK; i++) begin
        s[g*BLOCK+i] = x[g*BLOCK+i] ^ y[g*BLOCK+i] ^ rc;
        rc = (x[g*BLOCK+i] & y[g*BLOCK+i]) | ((x[g*BLOCK+i] ^ y[g*BLOCK+i]) & rc);
        p  = p & (x[g*BLOCK+i] ^ y[g*BLOCK+i]);
      end
      c = p ? c : rc;
    end
    return {c, s};
  endfunction

  assign adv = !out_valid_q || io.out_ready;
  assign io.in_ready = adv;

  // Each stage consumes the low SW bits of the remaining operands and appends to the finished low sum
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int R = WIDTH - k * SW;
    localparam int D = (k + 1) * SW;
    logic [R-1:0] ar_i, br_i;
    logic c_i, v_i, sat_i;
    logic [SW:0] r;
    logic [D-1:0] lo_o;
    if (k == 0) begin : g_in
      assign ar_i  = io.a;
      assign br_i  = io.b ^ {WIDTH{io.op[0]}};
      assign c_i   = io.cin ^ io.op[0];
      assign v_i   = io.in_valid;
      assign sat_i = io.op[1];
      assign lo_o  = r[SW-1:0];
    end else begin : g_in
      assign ar_i  = g_st[k-1].g_reg.ar_q;
      assign br_i  = g_st[k-1].g_reg.br_q;
      assign c_i   = g_st[k-1].g_reg.c_q;
      assign v_i   = g_st[k-1].g_reg.v_q;
      assign sat_i = g_st[k-1].g_reg.sat_q;
      assign lo_o  = {r[SW-1:0], g_st[k-1].g_reg.lo_q};
    end
    assign r = skip_add(ar_i[SW-1:0], br_i[SW-1:0], c_i);
    if (k < STAGES - 1) begin : g_reg
      logic [R-SW-1:0] ar_d, ar_q, br_d, br_q;
      logic [D-1:0] lo_d, lo_q;
      logic c_d, c_q, v_d, v_q, sat_d, sat_q;
      always_comb begin
        ar_d  = adv ? ar_i[R-1:SW] : ar_q;
        br_d  = adv ? br_i[R-1:SW] : br_q;
        lo_d  = adv ? lo_o : lo_q;
        c_d   = adv ? r[SW] : c_q;
        sat_d = adv ? sat_i : sat_q;
        v_d   = adv ? v_i : v_q;
      end
      always_ff @(posedge clk) begin
        {ar_q, br_q, lo_q, c_q, sat_q} <= {ar_d, br_d, lo_d, c_d, sat_d};
        v_q <= rst_n && v_d;
      end
    end
  end

  // Operand sign bits survive in the top of the last stage's remaining operands
  always_comb begin
    raw         = g_st[STAGES-1].lo_o;
    am          = g_st[STAGES-1].ar_i[SW-1];
    bm          = g_st[STAGES-1].br_i[SW-1];
    ovf_n       = (am == bm) && (raw[WIDTH-1] != am);
    sum_n       = (g_st[STAGES-1].sat_i && ovf_n) ? {am, {(WIDTH-1){!am}}} : raw;
    sum_d       = adv ? sum_n : sum_q;
    cout_d      = adv ? g_st[STAGES-1].r[SW] : cout_q;
    ovf_d       = adv ? ovf_n : ovf_q;
    zero_d      = adv ? (sum_n == '0) : zero_q;
    out_valid_d = adv ? g_st[STAGES-1].v_i : out_valid_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) {sum_q, cout_q, ovf_q, zero_q, out_valid_q} <= '0;
    else {sum_q, cout_q, ovf_q, zero_q, out_valid_q} <= {sum_d, cout_d, ovf_d, zero_d, out_valid_d};
  end

  assign io.sum       = sum_q;
  assign io.cout      = cout_q;
  assign io.ovf       = ovf_q;
  assign io.zero      = zero_q;
  assign io.out_valid = out_valid_q;
endmodule

// File: tb/tb_carryskip_addsub_pipe.sv
// tb_carryskip_addsub_pipe: table vectors, handshake corner sequences and random beats checked through a scoreboard queue
module tb_carryskip_addsub_pipe;
  typedef struct {
    logic [15:0] a, b;
    logic cin;
    logic [1:0] op;
    logic [15:0] sum;
    logic cout, ovf, zero;
  } vec_t;
  typedef struct {
    logic [15:0] sum;
    logic cout, ovf, zero;
    int acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0, fails = 0, cyc = 0;
  bit lat_chk = 1'b0, rnd_on = 1'b0;
  exp_t sb[$];
  exp_t m_e, e_t;
  vec_t tbl[14];
  logic [15:0] ra, rb;
  logic rc;
  logic [1:0] rop;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  carryskip_addsub_pipe_if #(.WIDTH(16)) io();
  carryskip_addsub_pipe #(.WIDTH(16), .BLOCK(4), .STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .io(io.slave));

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic [1:0] op);
    exp_t e;
    logic [15:0] bx;
    logic [16:0] r;
    bx     = op[0] ? ~b : b;
    r      = {1'b0, a} + {1'b0, bx} + {16'd0, cin ^ op[0]};
    e.cout = r[16];
    e.ovf  = (a[15] == bx[15]) && (r[15] != a[15]);
    e.sum  = (op[1] && e.ovf) ? (a[15] ? 16'h8000 : 16'h7FFF) : r[15:0];
    e.zero = (e.sum == 16'h0);
    e.acc  = 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic [1:0] op,
                      input exp_t e, input bit push);
    int n = 0;
    bit f = 1'b0;
    exp_t x;
    x = e;
    io.a = a; io.b = b; io.cin = cin; io.op = op; io.in_valid = 1'b1;
    do begin
      @(negedge clk);
      f = io.in_ready;
      if (f && push) begin
        x.acc = cyc;
        sb.push_back(x);
      end
      @(posedge clk); #1;
      n++;
    end while (!f && n < 50);
    if (!f) chk("send_timeout", 32'(f), 32'd1);
    io.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (sb.size() != 0 && n < 200);
    #1;
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && io.out_valid && io.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_result: got sum=%h with nothing expected", io.sum);
      end else begin
        m_e = sb.pop_front();
        checks++;
        if (io.sum !== m_e.sum || io.cout !== m_e.cout || io.ovf !== m_e.ovf || io.zero !== m_e.zero) begin
          fails++;
          $display("FAIL result: got sum=%h cout=%b ovf=%b zero=%b expected sum=%h cout=%b ovf=%b zero=%b",
                   io.sum, io.cout, io.ovf, io.zero, m_e.sum, m_e.cout, m_e.ovf, m_e.zero);
        end
        if (lat_chk) begin
          checks++;
          if (cyc - m_e.acc != 2) begin
            fails++;
            $display("FAIL latency: got %0d expected 2", cyc - m_e.acc);
          end
        end
      end
    end
  end

  initial begin
    tbl[0]  = '{16'h1234, 16'h0FCD, 1'b0, 2'b00, 16'h2201, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{16'hFFFF, 16'h0000, 1'b1, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{16'h8000, 16'h0001, 1'b0, 2'b11, 16'h8000, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{16'h8000, 16'h0001, 1'b0, 2'b01, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{16'h7FFF, 16'h0001, 1'b0, 2'b10, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{16'h7FFF, 16'h0001, 1'b0, 2'b00, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{16'h5555, 16'h5555, 1'b0, 2'b01, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{16'h0000, 16'h0000, 1'b1, 2'b01, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{16'h0001, 16'h0002, 1'b0, 2'b01, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{16'hFFFF, 16'hFFFF, 1'b1, 2'b00, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{16'h8000, 16'h8000, 1'b0, 2'b10, 16'h8000, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{16'h8000, 16'h8000, 1'b0, 2'b00, 16'h0000, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{16'h0F0F, 16'h00F1, 1'b0, 2'b00, 16'h1000, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{16'h7FFF, 16'hFFFF, 1'b0, 2'b11, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    io.in_valid = 1'b0; io.a = '0; io.b = '0; io.cin = 1'b0; io.op = 2'b00; io.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 32'(io.out_valid), 32'd0);
    chk("reset_flags", {12'd0, io.sum, io.cout, io.ovf, io.zero, 1'b0}, 32'd0);
    chk("reset_in_ready", 32'(io.in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    lat_chk = 1'b1;
    for (int i = 0; i < 14; i++) begin
      e_t.sum = tbl[i].sum; e_t.cout = tbl[i].cout; e_t.ovf = tbl[i].ovf; e_t.zero = tbl[i].zero; e_t.acc = 0;
      send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].op, e_t, 1'b1);
    end
    drain("table_drained");
    lat_chk = 1'b0;

    io.out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 4; i++)
          send(16'(i), 16'(i), 1'b0, 2'b00, model(16'(i), 16'(i), 1'b0, 2'b00), 1'b1);
      end
      begin
        int n = 0;
        while (!io.out_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        chk("bp_first_valid", 32'(io.out_valid), 32'd1);
        repeat (3) begin
          chk("bp_in_ready", 32'(io.in_ready), 32'd0);
          chk("bp_hold_sum", 32'(io.sum), 32'h0002);
          @(negedge clk);
        end
        @(posedge clk); #1;
        io.out_ready = 1'b1;
      end
    join
    drain("bp_drained");

    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rop = 2'($urandom);
          if (i % 8 == 0) rb = ra;
          send(ra, rb, rc, rop, model(ra, rb, rc, rop), 1'b1);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          io.out_ready = ($urandom_range(0, 3) != 0);
        end
        io.out_ready = 1'b1;
      end
    join
    drain("random_drained");

    io.out_ready = 1'b0;
    send(16'h0001, 16'h0002, 1'b0, 2'b00, model(16'h0001, 16'h0002, 1'b0, 2'b00), 1'b0);
    send(16'h0003, 16'h0004, 1'b0, 2'b00, model(16'h0003, 16'h0004, 1'b0, 2'b00), 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    io.out_ready = 1'b1;
    @(negedge clk);
    chk("rst_flush_valid", 32'(io.out_valid), 32'd0);
    chk("rst_flush_sum", 32'(io.sum), 32'd0);
    chk("rst_in_ready", 32'(io.in_ready), 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk("rst_no_ghost", 32'(io.out_valid), 32'd0);
    end
    @(posedge clk); #1;
    lat_chk = 1'b1;
    send(16'h0005, 16'h0006, 1'b0, 2'b00, '{16'h000B, 1'b0, 1'b0, 1'b0, 0}, 1'b1);
    drain("rst_new_beat");
    lat_chk = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/carryskip_addsub_pipe.md
Name: carryskip_addsub_pipe

Overview:
Parametrised, pipelined successor to the 8-bit carry-skip adder. It is a WIDTH-bit carry-skip add/subtract unit with BLOCK-bit skip groups split across STAGES register stages. Each result carries signed-saturation support and status flags. A valid/ready handshake with backpressure on both sides lets it sit between an operand source and a result consumer inside a tt_um_* top, or stand alone as a datapath core.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of BLOCK
BLOCK, 4, carry-skip group size in bits
STAGES, 2, pipeline depth in cycles; must be >=1 and must divide WIDTH/BLOCK

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  operand beat valid
in_ready  out  1  unit accepts beat this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in (add) / borrow-in (sub)
op  in  2  op[0]=sub, op[1]=saturate (signed)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
sum  out  WIDTH  result
cout  out  1  carry-out (sub: 1 = no borrow)
ovf  out  1  signed overflow of the unsaturated result
zero  out  1  final sum == 0

Behaviour:
- Accept: a beat is accepted when in_valid && in_ready. Emit: a result is consumed when out_valid && out_ready.
- Arithmetic:
  - Add: {cout,raw} = a + b + cin.
  - Sub: {cout,raw} = a + ~b + ~cin, i.e. a - b - cin.
  - ovf = signed overflow of raw: operand-sign rule using b or ~b.
- Saturation: if op[1] && ovf, sum = a[WIDTH-1] ? 100..0 : 011..1. Otherwise sum = raw. Saturation never changes cout or ovf.
- zero is computed on the final (post-saturation) sum.
- Carry-skip structure:
  - Each BLOCK group produces group propagate P = &(a^b') and ripple carry; group carry-out = P ? group cin : ripple cout.
  - Stage k (0..STAGES-1) resolves groups k*G .. (k+1)*G-1, where G = WIDTH/(BLOCK*STAGES).
  - Between stages, register: the inter-stage carry, the completed low sum bits, the unprocessed high operand bits (b already conditionally inverted), a[WIDTH-1], op[1], and the valid bit.
  - Flags and saturation are resolved in the final stage.
- Latency is exactly STAGES cycles from accept to out_valid when there is no backpressure. Throughput is 1 result/cycle.
- Flow control:
  - The whole pipeline advances when advance = !out_valid || out_ready. Global stall, no bubble collapsing.
  - in_ready = advance; combinational from out_valid/out_ready only, independent of in_valid.
  - Bubbles (in_valid=0 while advancing) propagate as invalid slots.
- While out_valid && !out_ready: sum, cout, ovf and zero hold stable, and no internal register changes.
- Ordering: results leave strictly in acceptance order. No drop, no duplication.
- Reset:
  - While rst_n=0 at a clock edge, all stage valid bits are cleared, and sum/cout/ovf/zero/out_valid are set to 0.
  - in_ready reads 1 after reset.
  - Reset mid-operation flushes all in-flight beats; none emerge after reset deasserts.
- Inputs are sampled only on accept; a/b/op may change freely otherwise.
- STAGES=1 is a single-cycle registered adder; the same handshake rules apply.

Test Plan:
(All with WIDTH=16, BLOCK=4, STAGES=2.)
- Add: a=0x1234, b=0x0FCD, cin=0, op=00, out_ready=1 -> exactly 2 cycles after accept: sum=0x2201, cout=0, ovf=0, zero=0.
- Full skip chain: a=0xFFFF, b=0x0000, cin=1, op=00 -> sum=0x0000, cout=1, ovf=0, zero=1.
- Saturating sub: a=0x8000, b=0x0001, cin=0, op=11 -> sum=0x8000, ovf=1, cout=1. Same beat with op=01 -> sum=0x7FFF, ovf=1.
- Saturating add: a=0x7FFF, b=0x0001, op=10 -> sum=0x7FFF, ovf=1, cout=0, zero=0. With op=00 -> sum=0x8000, ovf=1.
- Backpressure: present 4 back-to-back beats (1+1, 2+2, 3+3, 4+4), then hold out_ready=0 for 3 cycles after the first out_valid.
  - While stalled: in_ready=0, sum stays 0x0002 and stable.
  - After release: sums 0x0002, 0x0004, 0x0006, 0x0008 in order, none lost or repeated.
- Reset mid-flight: accept 2 beats, assert rst_n=0 for 1 edge -> out_valid=0 and sum=0 next cycle. No result appears in the following 4 cycles. A new beat 5+6 then gives sum=0x000B with latency 2.
